// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file's single write port among
// NUM_REQ writeback requesters, with a registered write stage and pending-write mask.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      hold,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_rd,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rf_write_enable,
  output logic [ADDR_W-1:0]         rf_rd,
  output logic [DATA_W-1:0]         rf_write_data,
  output logic [31:0]               pending_mask,
  output logic [2:0]                grant_idx
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [PTR_W:0] NUM_REQ_EXT = (PTR_W+1)'(NUM_REQ);

  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  rd_q, rd_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [2:0]         gidx_q, gidx_d;

  logic [NUM_REQ-1:0] grant_s;
  logic               found_s;
  logic               accept_s;
  logic [ADDR_W-1:0]  win_rd_s;
  logic [DATA_W-1:0]  win_data_s;
  logic [2:0]         win_idx_s;
  logic [PTR_W-1:0]   win_next_s;
  logic [PTR_W:0]     sum_s;
  logic [PTR_W:0]     cand_s;

  // Round-robin search starting at rr_ptr; the wrap is explicit so non-power-of-two counts work.
  always_comb begin
    grant_s    = '0;
    found_s    = 1'b0;
    win_rd_s   = '0;
    win_data_s = '0;
    win_idx_s  = 3'd0;
    win_next_s = '0;
    sum_s      = '0;
    cand_s     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum_s  = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      cand_s = (sum_s >= NUM_REQ_EXT) ? (sum_s - NUM_REQ_EXT) : sum_s;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found_s && req_valid[i] && (cand_s == (PTR_W+1)'(i))) begin
          found_s    = 1'b1;
          grant_s[i] = 1'b1;
          win_rd_s   = req_rd[i*ADDR_W +: ADDR_W];
          win_data_s = req_data[i*DATA_W +: DATA_W];
          win_idx_s  = 3'(i);
          win_next_s = (i == NUM_REQ-1) ? '0 : PTR_W'(i+1);
        end else begin
          grant_s[i] = grant_s[i];
        end
      end
    end
    if (hold || reset) begin
      grant_s = '0;
    end else begin
      grant_s = grant_s;
    end
  end

  assign req_ready = grant_s;
  assign accept_s  = |grant_s;

  // Output-stage next state; writes to x0 consume the grant but never strobe.
  always_comb begin
    rr_ptr_d = accept_s ? win_next_s : rr_ptr_q;
    we_d     = accept_s && (win_rd_s != '0);
    rd_d     = accept_s ? win_rd_s   : rd_q;
    data_d   = accept_s ? win_data_s : data_q;
    gidx_d   = accept_s ? win_idx_s  : gidx_q;
  end

  // Pointer and registered write-port state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q <= '0;
      we_q     <= 1'b0;
      rd_q     <= '0;
      data_q   <= '0;
      gidx_q   <= 3'd0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      we_q     <= we_d;
      rd_q     <= rd_d;
      data_q   <= data_d;
      gidx_q   <= gidx_d;
    end
  end

  // Pending-write mask covers both requested and in-flight writes; x0 never pends.
  always_comb begin
    pending_mask = 32'd0;
    for (int r = 1; r < 32; r++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        pending_mask[r] = pending_mask[r] |
          (req_valid[i] && (32'(req_rd[i*ADDR_W +: ADDR_W]) == 32'(r)));
      end
      pending_mask[r] = pending_mask[r] | (we_q && (32'(rd_q) == 32'(r)));
    end
  end

  assign rf_write_enable = we_q;
  assign rf_rd           = rd_q;
  assign rf_write_data   = data_q;
  assign grant_idx       = gidx_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus randomized
// traffic checked against a round-robin reference model.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        hold;
  logic [2:0]  req_valid;
  logic [4:0]  rd_a [3];
  logic [31:0] data_a [3];
  logic [14:0] req_rd;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        rf_write_enable;
  logic [4:0]  rf_rd;
  logic [31:0] rf_write_data;
  logic [31:0] pending_mask;
  logic [2:0]  grant_idx;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int          m_ptr;
  logic        m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  int          m_gidx;

  assign req_rd   = {rd_a[2], rd_a[1], rd_a[0]};
  assign req_data = {data_a[2], data_a[1], data_a[0]};

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.NUM_REQ(3), .DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .hold(hold),
    .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data),
    .req_ready(req_ready), .rf_write_enable(rf_write_enable),
    .rf_rd(rf_rd), .rf_write_data(rf_write_data),
    .pending_mask(pending_mask), .grant_idx(grant_idx)
  );

  function automatic int model_grant();
    if (hold || reset) return -1;
    for (int k = 0; k < 3; k++) begin
      if (req_valid[(m_ptr + k) % 3]) return (m_ptr + k) % 3;
    end
    return -1;
  endfunction

  function automatic logic [2:0] model_ready();
    int g;
    logic [2:0] r;
    g = model_grant();
    r = 3'd0;
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] model_mask();
    logic [31:0] m;
    m = 32'd0;
    for (int i = 0; i < 3; i++) if (req_valid[i]) m[rd_a[i]] = 1'b1;
    if (m_we) m[m_rd] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_we = 1'b0; m_rd = 5'd0; m_data = 32'd0; m_gidx = 0;
  endtask

  task automatic clear_inputs();
    hold = 1'b0; req_valid = 3'b000;
    for (int i = 0; i < 3; i++) begin rd_a[i] = 5'd0; data_a[i] = 32'd0; end
  endtask

  // one clock edge; model advances using the inputs stable at the edge
  task automatic tick();
    int g;
    g = model_grant();
    @(posedge clk);
    if (g >= 0) begin
      m_ptr = (g + 1) % 3; m_gidx = g; m_rd = rd_a[g]; m_data = data_a[g];
      m_we = (rd_a[g] != 5'd0);
    end else begin
      m_we = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    clear_inputs();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    model_reset();
    req_valid = 3'b010; rd_a[1] = 5'd4;
    #2;
    n_checks++;
    if (req_ready !== 3'b000) begin n_errors++; $display("FAIL reset_ready: got %b want 000", req_ready); end
    n_checks++;
    if (pending_mask !== 32'h10) begin n_errors++; $display("FAIL reset_mask: got %h want 00000010", pending_mask); end
    n_checks++;
    if ({rf_write_enable, rf_rd, rf_write_data, grant_idx} !== 41'd0) begin
      n_errors++; $display("FAIL reset_outputs: got we=%b rd=%0d data=%h gidx=%0d want all 0",
                           rf_write_enable, rf_rd, rf_write_data, grant_idx);
    end
    @(negedge clk);
    reset = 1'b0;
    clear_inputs();
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 3'b001; rd_a[0] = 5'd5; data_a[0] = 32'hDEADBEEF;
    #1;
    n_checks++;
    if (req_ready !== 3'b001) begin n_errors++; $display("FAIL single_ready: got %b want 001", req_ready); end
    n_checks++;
    if (pending_mask[5] !== 1'b1) begin n_errors++; $display("FAIL single_mask_req: got %b want 1", pending_mask[5]); end
    tick();
    req_valid = 3'b000;
    #1;
    n_checks++;
    if (rf_write_enable !== 1'b1 || rf_rd !== 5'd5 || rf_write_data !== 32'hDEADBEEF) begin
      n_errors++; $display("FAIL single_write: got we=%b rd=%0d data=%h want 1 5 deadbeef",
                           rf_write_enable, rf_rd, rf_write_data);
    end
    n_checks++;
    if (pending_mask !== 32'h20) begin n_errors++; $display("FAIL single_mask_flight: got %h want 00000020", pending_mask); end
    tick();
    n_checks++;
    if (rf_write_enable !== 1'b0) begin n_errors++; $display("FAIL single_strobe_len: got %b want 0", rf_write_enable); end
  endtask

  task automatic test_round_robin();
    do_reset();
    req_valid = 3'b111;
    for (int i = 0; i < 3; i++) begin rd_a[i] = 5'(i + 1); data_a[i] = $urandom; end
    for (int c = 0; c < 6; c++) begin
      #1;
      n_checks++;
      if (req_ready !== (3'b001 << (c % 3))) begin
        n_errors++; $display("FAIL rr_grant c=%0d: got %b want %b", c, req_ready, 3'b001 << (c % 3));
      end
      tick();
      n_checks++;
      if (rf_rd !== 5'((c % 3) + 1) || rf_write_data !== data_a[c % 3] || grant_idx !== 3'(c % 3)) begin
        n_errors++; $display("FAIL rr_write c=%0d: got rd=%0d data=%h gidx=%0d want rd=%0d data=%h gidx=%0d",
                             c, rf_rd, rf_write_data, grant_idx, (c % 3) + 1, data_a[c % 3], c % 3);
      end
    end
    req_valid = 3'b000;
    tick();
  endtask

  task automatic test_x0();
    do_reset();
    req_valid = 3'b010; rd_a[1] = 5'd0; data_a[1] = 32'h12345678;
    #1;
    n_checks++;
    if (req_ready !== 3'b010) begin n_errors++; $display("FAIL x0_ready: got %b want 010", req_ready); end
    n_checks++;
    if (pending_mask !== 32'd0) begin n_errors++; $display("FAIL x0_mask: got %h want 0", pending_mask); end
    tick();
    req_valid = 3'b111; rd_a[0] = 5'd1; rd_a[2] = 5'd3;
    #1;
    n_checks++;
    if (rf_write_enable !== 1'b0) begin n_errors++; $display("FAIL x0_strobe: got %b want 0", rf_write_enable); end
    n_checks++;
    if (req_ready !== 3'b100) begin n_errors++; $display("FAIL x0_ptr_advance: got %b want 100", req_ready); end
    req_valid = 3'b000;
    tick();
  endtask

  task automatic test_hold_conflict();
    do_reset();
    hold = 1'b1; req_valid = 3'b101;
    rd_a[0] = 5'd7; rd_a[2] = 5'd7; data_a[0] = 32'hAAAA0000; data_a[2] = 32'hBBBB2222;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (req_ready !== 3'b000 || pending_mask[7] !== 1'b1 || rf_write_enable !== 1'b0) begin
        n_errors++; $display("FAIL hold c=%0d: got ready=%b pm7=%b we=%b want 000 1 0",
                             c, req_ready, pending_mask[7], rf_write_enable);
      end
      tick();
    end
    hold = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 3'b001) begin n_errors++; $display("FAIL conflict_first: got %b want 001", req_ready); end
    tick();
    req_valid = 3'b100;
    #1;
    n_checks++;
    if (req_ready !== 3'b100 || rf_write_enable !== 1'b1 || rf_rd !== 5'd7 || rf_write_data !== 32'hAAAA0000) begin
      n_errors++; $display("FAIL conflict_w0: got ready=%b we=%b rd=%0d data=%h want 100 1 7 aaaa0000",
                           req_ready, rf_write_enable, rf_rd, rf_write_data);
    end
    tick();
    req_valid = 3'b000;
    #1;
    n_checks++;
    if (rf_write_enable !== 1'b1 || rf_rd !== 5'd7 || rf_write_data !== 32'hBBBB2222 || grant_idx !== 3'd2) begin
      n_errors++; $display("FAIL conflict_w2: got we=%b rd=%0d data=%h gidx=%0d want 1 7 bbbb2222 2",
                           rf_write_enable, rf_rd, rf_write_data, grant_idx);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick();
    req_valid = 3'b010; rd_a[1] = 5'd9; data_a[1] = 32'h0BADF00D;
    tick();
    req_valid = 3'b111;
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (rf_write_enable !== 1'b0 || rf_rd !== 5'd0) begin
      n_errors++; $display("FAIL midreset_drop: got we=%b rd=%0d want 0 0", rf_write_enable, rf_rd);
    end
    n_checks++;
    if (req_ready !== 3'b000) begin n_errors++; $display("FAIL midreset_ready: got %b want 000", req_ready); end
    @(posedge clk); #1;
    n_checks++;
    if (rf_write_enable !== 1'b0) begin n_errors++; $display("FAIL midreset_hold: got %b want 0", rf_write_enable); end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (req_ready !== 3'b001) begin n_errors++; $display("FAIL midreset_ptr: got %b want 001", req_ready); end
    req_valid = 3'b000;
    tick();
  endtask

  task automatic test_random();
    logic [2:0] exp_ready;
    logic [31:0] exp_mask;
    do_reset();
    for (int c = 0; c < 300; c++) begin
      req_valid = 3'($urandom_range(0, 7));
      hold = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < 3; i++) begin
        rd_a[i] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 2)) : 5'($urandom);
        data_a[i] = $urandom;
      end
      #1;
      exp_ready = model_ready();
      exp_mask = model_mask();
      n_checks++;
      if (req_ready !== exp_ready || pending_mask !== exp_mask) begin
        n_errors++; $display("FAIL rand_comb c=%0d: got ready=%b mask=%h want %b %h",
                             c, req_ready, pending_mask, exp_ready, exp_mask);
      end
      tick();
      n_checks++;
      if (rf_write_enable !== m_we || rf_rd !== m_rd || rf_write_data !== m_data || grant_idx !== 3'(m_gidx)) begin
        n_errors++; $display("FAIL rand_out c=%0d: got we=%b rd=%0d data=%h gidx=%0d want %b %0d %h %0d",
                             c, rf_write_enable, rf_rd, rf_write_data, grant_idx, m_we, m_rd, m_data, m_gidx);
      end
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_x0();
    test_hold_conflict();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port among NUM_REQ writeback requesters (e.g. ALU, load unit, CSR unit) using round-robin arbitration with valid/ready handshakes.
- Registers the winning request and drives it onto the register file's write_enable/rd/write_data inputs.
- Exports a per-register pending-write mask that the decode/hazard logic uses to stall reads of registers whose writes are not yet committed.

Parameters:
NUM_REQ, 3, number of writeback requesters (2..8)
DATA_W, 32, write data width
ADDR_W, 5, register index width

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high reset
hold  in  1  when 1, no request is granted (all req_ready = 0)
req_valid  in  NUM_REQ  per-requester valid
req_rd  in  NUM_REQ*ADDR_W  destination index; requester i occupies bits [i*ADDR_W +: ADDR_W]
req_data  in  NUM_REQ*DATA_W  write data; requester i occupies bits [i*DATA_W +: DATA_W]
req_ready  out  NUM_REQ  one-hot-or-zero grant; transfer on valid&ready at the clock edge
rf_write_enable  out  1  registered write strobe to the register file
rf_rd  out  ADDR_W  registered destination index
rf_write_data  out  DATA_W  registered write data
pending_mask  out  32  bit r = 1 while a write to xr is requested or in flight
grant_idx  out  3  index of the last accepted requester (registered, debug)

Behaviour:
- Reset (async, active-high): rr_ptr = 0, rf_write_enable = 0, rf_rd = 0, rf_write_data = 0, grant_idx = 0. While reset is high, req_ready = 0 and pending_mask reflects only req_valid (bit 0 forced to 0).
- Asserting reset mid-operation drops any in-flight write in the output stage. No write reaches the register file from that stage.
- Arbitration is combinational from req_valid, rr_ptr and hold.
  - Search order is rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_REQ.
  - The first valid requester found gets req_ready = 1; all other requesters get 0.
  - hold = 1 forces req_ready = 0.
- req_ready never depends on req_ready itself. A requester may drop valid before it is granted, with no side effect.
- On an accepted transfer from requester g at edge N:
  - rr_ptr <= (g+1) mod NUM_REQ, and grant_idx <= g.
  - rf_rd <= req_rd[g] and rf_write_data <= req_data[g].
  - rf_write_enable <= (req_rd[g] != 0).
- Latency: the write strobe is high for exactly the cycle after acceptance. The register file commits the write on the following edge.
- Throughput: one acceptance per cycle; the output stage never back-pressures.
- No acceptance in a cycle: rf_write_enable <= 0. rf_rd, rf_write_data and rr_ptr hold their values.
- Writes to x0:
  - The request is accepted normally and consumes the grant.
  - rr_ptr advances.
  - rf_write_enable stays 0.
- Identical rd from two requesters in the same cycle: only the winner is accepted. The loser stays valid and wins in a later cycle, so ordering follows grant order.
- pending_mask is combinational. Bit r is 1 if either:
  - some i has req_valid[i] and req_rd[i] == r, or
  - rf_write_enable and rf_rd == r.
  - Bit 0 is always 0.
- rr_ptr must never exceed NUM_REQ-1. For non-power-of-two NUM_REQ, the wrap is explicit.

Test Plan:
- Reset then single request: reset pulse; req_valid=3'b001, rd=5, data=0xDEADBEEF.
  - req_ready=3'b001.
  - Next cycle: rf_write_enable=1, rf_rd=5, rf_write_data=0xDEADBEEF.
  - The cycle after: rf_write_enable=0.
  - pending_mask[5]=1 across both cycles.
- Round-robin fairness: all three requesters valid continuously, with rd=1,2,3.
  - Grants cycle 0,1,2,0,1,2; rf_rd sequence 1,2,3,1,2,3.
  - No requester is skipped over 6 cycles.
- x0 write: requester 1 writes rd=0, data=0x12345678.
  - req_ready[1]=1 and rr_ptr advances to 2.
  - rf_write_enable stays 0; pending_mask=0.
- hold and conflict: hold=1 with requesters 0 and 2 valid, both rd=7.
  - req_ready=0 for 3 cycles; pending_mask[7]=1.
  - After hold drops: requester 0 writes first, then requester 2 on the next cycle, with their respective data.
- Reset mid-operation: accept rd=9, then assert reset asynchronously mid-cycle, before the next edge.
  - rf_write_enable goes to 0 immediately and the write is never seen.
  - rr_ptr=0 after reset.
